// File: rtl/brisc_pkg.sv
// BRISC shared types and widths.
// Widths, the NOP word and the fetch state encoding.
package brisc_pkg;

  localparam int BRISC_ADDR_W  = 5;
  localparam int BRISC_INSTR_W = 16;

  localparam logic [BRISC_INSTR_W-1:0] NOP =
    16'h0000;

  typedef enum logic [1:0] {
    WAIT_LOAD = 2'd0,
    FETCH     = 2'd1,
    DONE      = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch bus: instruction memory read port plus
// the fetch->decode bundle and decode control.
//  master (fetch) drives program_counter, if_*, fetch_done
//  slave  (mem/decode) drives load_done, instruction,
//         stall, branch_taken, branch_target
interface instruction_fetch_if
  import brisc_pkg::*;
#(
  parameter int ADDR_W  = BRISC_ADDR_W,
  parameter int INSTR_W = BRISC_INSTR_W
);

  logic               load_done;
  logic [INSTR_W-1:0] instruction;
  logic [ADDR_W-1:0]  program_counter;
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instruction;
  logic [ADDR_W-1:0]  if_pc;
  logic               fetch_done;

  modport master (
    input  load_done,
    input  instruction,
    output program_counter,
    input  stall,
    input  branch_taken,
    input  branch_target,
    output if_valid,
    output if_instruction,
    output if_pc,
    output fetch_done
  );

  modport slave (
    output load_done,
    output instruction,
    input  program_counter,
    output stall,
    output branch_taken,
    output branch_target,
    input  if_valid,
    input  if_instruction,
    input  if_pc,
    input  fetch_done
  );

endinterface

// File: rtl/brisc_pc_counter.sv
// BRISC program counter register.
// Ports: CLK, RST_N, load/load_val (redirect or
// reset value), en (+1 mod 2**ADDR_W), pc, at_max.
module brisc_pc_counter
  import brisc_pkg::*;
#(
  parameter int          ADDR_W   = BRISC_ADDR_W,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              en,
  output logic [ADDR_W-1:0] pc,
  output logic              at_max
);

  localparam logic [ADDR_W-1:0] RST_PC =
    ADDR_W'(RESET_PC);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc <= RST_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (en) begin
      pc <= pc + 1'b1;
    end
  end

  assign at_max = &pc;

endmodule

// File: rtl/instruction_fetch.sv
// BRISC fetch stage: PC, memory address, fetch
// register, stall/redirect/halt and load gating.
// Ports: CLK, RST_N, bus (instruction_fetch_if.master)
//  carrying load_done, instruction, program_counter,
//  stall, branch_*, if_valid/if_instruction/if_pc,
//  fetch_done.
module instruction_fetch
  import brisc_pkg::*;
#(
  parameter int          ADDR_W   = BRISC_ADDR_W,
  parameter int          INSTR_W  = BRISC_INSTR_W,
  parameter int unsigned RESET_PC = 0,
  parameter bit          WRAP_EN  = 1'b1
) (
  input  logic                CLK,
  input  logic                RST_N,
  instruction_fetch_if.master bus
);

  localparam logic [ADDR_W-1:0] RST_PC =
    ADDR_W'(RESET_PC);

  fetch_state_e state_q, state_d;

  logic               pc_load;
  logic [ADDR_W-1:0]  pc_load_val;
  logic               pc_en;
  logic [ADDR_W-1:0]  pc;
  logic               pc_max;

  logic               vld_q, vld_d;
  logic [INSTR_W-1:0] ins_q, ins_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               done_q;

  brisc_pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (pc_load),
    .load_val (pc_load_val),
    .en       (pc_en),
    .pc       (pc),
    .at_max   (pc_max)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= WAIT_LOAD;
      vld_q   <= 1'b0;
      ins_q   <= INSTR_W'(NOP);
      ipc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      ins_q   <= ins_d;
      ipc_q   <= ipc_d;
      done_q  <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_load     = 1'b0;
    pc_load_val = RST_PC;
    pc_en       = 1'b0;
    vld_d       = vld_q;
    ins_d       = ins_q;
    ipc_d       = ipc_q;
    unique case (state_q)
      WAIT_LOAD: begin
        vld_d   = 1'b0;
        pc_load = 1'b1;
        if (bus.load_done) state_d = FETCH;
      end
      FETCH: begin
        if (!bus.load_done) begin
          state_d = WAIT_LOAD;
          pc_load = 1'b1;
          vld_d   = 1'b0;
        end else if (bus.branch_taken) begin
          pc_load     = 1'b1;
          pc_load_val = bus.branch_target;
          vld_d       = 1'b0;
        end else if (!bus.stall) begin
          ins_d = bus.instruction;
          ipc_d = pc;
          vld_d = 1'b1;
          // Without wrap the last word is still
          // delivered; PC parks on it.
          if (!WRAP_EN && pc_max) begin
            state_d = DONE;
          end else begin
            pc_en = 1'b1;
          end
        end
      end
      DONE: begin
        if (!bus.load_done) begin
          state_d = WAIT_LOAD;
          pc_load = 1'b1;
          vld_d   = 1'b0;
        end else if (bus.branch_taken) begin
          state_d     = FETCH;
          pc_load     = 1'b1;
          pc_load_val = bus.branch_target;
          vld_d       = 1'b0;
        end else if (!bus.stall) begin
          vld_d = 1'b0;
        end
      end
      default: begin
        state_d = WAIT_LOAD;
        pc_load = 1'b1;
        vld_d   = 1'b0;
      end
    endcase
  end

  assign bus.program_counter = pc;
  assign bus.if_valid        = vld_q;
  assign bus.if_instruction  = ins_q;
  assign bus.if_pc           = ipc_q;
  assign bus.fetch_done      = done_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch, one
// wrapping and one halting instance.
module tb_instruction_fetch;

  logic CLK;
  logic RST_N;

  int n_pass;
  int n_total;

  logic [15:0] mem [32];

  instruction_fetch_if #(.ADDR_W(5), .INSTR_W(16)) f1 ();
  instruction_fetch_if #(.ADDR_W(5), .INSTR_W(16)) f0 ();

  instruction_fetch #(
    .ADDR_W(5), .INSTR_W(16), .RESET_PC(0), .WRAP_EN(1'b1)
  ) dut_wrap (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (f1)
  );

  instruction_fetch #(
    .ADDR_W(5), .INSTR_W(16), .RESET_PC(0), .WRAP_EN(1'b0)
  ) dut_halt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (f0)
  );

  assign f1.instruction = mem[f1.program_counter];
  assign f0.instruction = mem[f0.program_counter];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] word(input int a);
    logic [15:0] w;
    w = 16'hA000 | 16'(a);
    if (a == 0) w = 16'h4008;
    if (a == 4) w = 16'h5201;
    return w;
  endfunction

  initial begin
    n_pass  = 0;
    n_total = 0;
    for (int i = 0; i < 32; i++) mem[i] = word(i);

    RST_N = 1'b0;
    f1.load_done = 0; f1.stall = 0;
    f1.branch_taken = 0; f1.branch_target = '0;
    f0.load_done = 0; f0.stall = 0;
    f0.branch_taken = 0; f0.branch_target = '0;

    repeat (3) step();
    RST_N = 1'b1;
    repeat (17) step();
    check("rst_valid", 32'(f1.if_valid), 0);
    check("rst_pc", 32'(f1.program_counter), 0);
    check("rst_ifpc", 32'(f1.if_pc), 0);
    check("rst_ins", 32'(f1.if_instruction), 0);
    check("rst_done", 32'(f1.fetch_done), 0);

    // load complete
    f1.load_done = 1;
    step();
    check("ld1_valid", 32'(f1.if_valid), 0);
    check("ld1_pc", 32'(f1.program_counter), 0);
    step();
    check("ld2_valid", 32'(f1.if_valid), 1);
    check("ld2_ifpc", 32'(f1.if_pc), 0);
    check("ld2_ins", 32'(f1.if_instruction), 32'h4008);
    check("ld2_pc", 32'(f1.program_counter), 1);
    for (int a = 1; a <= 4; a++) begin
      step();
      check("run_ifpc", 32'(f1.if_pc), 32'(a));
      check("run_pc", 32'(f1.program_counter), 32'(a + 1));
    end
    check("run_ins4", 32'(f1.if_instruction), 32'h5201);

    // stall 3 cycles
    f1.stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stl_ifpc", 32'(f1.if_pc), 4);
      check("stl_ins", 32'(f1.if_instruction), 32'h5201);
      check("stl_pc", 32'(f1.program_counter), 5);
      check("stl_valid", 32'(f1.if_valid), 1);
    end
    f1.stall = 0;
    step();
    check("rel_ifpc", 32'(f1.if_pc), 5);
    check("rel_pc", 32'(f1.program_counter), 6);

    // branch beats stall
    f1.branch_taken = 1; f1.branch_target = 5'd2;
    f1.stall = 1;
    step();
    check("br_valid", 32'(f1.if_valid), 0);
    check("br_pc", 32'(f1.program_counter), 2);
    f1.branch_taken = 0; f1.stall = 0;
    step();
    check("br2_valid", 32'(f1.if_valid), 1);
    check("br2_ifpc", 32'(f1.if_pc), 2);
    check("br2_ins", 32'(f1.if_instruction), 32'hA002);
    check("br2_pc", 32'(f1.program_counter), 3);

    // reload mid-run at if_pc=9
    repeat (7) step();
    check("pre_rl_ifpc", 32'(f1.if_pc), 9);
    f1.load_done = 0;
    step();
    check("rl_valid", 32'(f1.if_valid), 0);
    check("rl_pc", 32'(f1.program_counter), 0);
    f1.branch_taken = 1; f1.branch_target = 5'd7;
    step();
    check("rl_ign_br", 32'(f1.program_counter), 0);
    f1.branch_taken = 0;
    f1.load_done = 1;
    step();
    check("rl2_valid", 32'(f1.if_valid), 0);
    step();
    check("rl3_valid", 32'(f1.if_valid), 1);
    check("rl3_ifpc", 32'(f1.if_pc), 0);
    check("rl3_pc", 32'(f1.program_counter), 1);

    // wrap 31 -> 0
    f1.branch_taken = 1; f1.branch_target = 5'd30;
    step();
    f1.branch_taken = 0;
    check("wr_pc30", 32'(f1.program_counter), 30);
    step();
    check("wr_ifpc30", 32'(f1.if_pc), 30);
    step();
    check("wr_ifpc31", 32'(f1.if_pc), 31);
    check("wr_ins31", 32'(f1.if_instruction), 32'hA01F);
    check("wr_pc0", 32'(f1.program_counter), 0);
    step();
    check("wr_ifpc0", 32'(f1.if_pc), 0);
    check("wr_valid0", 32'(f1.if_valid), 1);
    check("wr_done", 32'(f1.fetch_done), 0);
    check("halt_idle", 32'(f0.if_valid), 0);

    // async reset between edges
    #2;
    RST_N = 1'b0;
    #1;
    check("ar_valid", 32'(f1.if_valid), 0);
    check("ar_pc", 32'(f1.program_counter), 0);
    check("ar_ifpc", 32'(f1.if_pc), 0);
    check("ar_ins", 32'(f1.if_instruction), 0);
    #2;
    RST_N = 1'b1;

    // halting instance
    f0.load_done = 1;
    step();
    check("h_fetch_pc", 32'(f0.program_counter), 0);
    f0.branch_taken = 1; f0.branch_target = 5'd29;
    step();
    f0.branch_taken = 0;
    check("h_pc29", 32'(f0.program_counter), 29);
    step();
    step();
    check("h_ifpc30", 32'(f0.if_pc), 30);
    check("h_pc31", 32'(f0.program_counter), 31);
    check("h_nodone", 32'(f0.fetch_done), 0);
    step();
    check("h_ifpc31", 32'(f0.if_pc), 31);
    check("h_valid31", 32'(f0.if_valid), 1);
    check("h_done", 32'(f0.fetch_done), 1);
    check("h_pc_hold", 32'(f0.program_counter), 31);
    f0.stall = 1;
    step();
    check("h_stl_valid", 32'(f0.if_valid), 1);
    check("h_stl_done", 32'(f0.fetch_done), 1);
    f0.stall = 0;
    step();
    check("h_cons_valid", 32'(f0.if_valid), 0);
    check("h_cons_done", 32'(f0.fetch_done), 1);
    check("h_cons_pc", 32'(f0.program_counter), 31);
    step();
    check("h_stay_done", 32'(f0.fetch_done), 1);
    f0.branch_taken = 1; f0.branch_target = 5'd5;
    step();
    f0.branch_taken = 0;
    check("h_br_done", 32'(f0.fetch_done), 0);
    check("h_br_pc", 32'(f0.program_counter), 5);
    check("h_br_valid", 32'(f0.if_valid), 0);
    step();
    check("h_br_ifpc", 32'(f0.if_pc), 5);
    check("h_br_ins", 32'(f0.if_instruction), 32'hA005);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
